// File: rtl/rf_pkg.sv
// Shared register-file constants and helpers for the writeback arbiter.
// The multi-hot helper works on up to 8 requesters.
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_REGS = 32;

  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = '0;

  // True when two or more bits of the vector are set.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin grant: combinational one-hot grant, zero during reset.
// The search starts just after last_grant, which moves only when the grant is used.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_grant_q;
  logic [IW-1:0] last_grant_d;
  logic [IW-1:0] grant_idx;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant_q;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant_q) + k) % N;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    if (found && !rst) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance && found && !rst) begin
      last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IW'(N - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant, one-cycle registered write, read bypass.
// Never stalls downstream; optional conflict counter under RF_WB_ARB_STATS_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_indata,
  input  logic [ADDR_W-1:0]         rs1,
  input  logic [ADDR_W-1:0]         rs2,
  input  logic [DATA_W-1:0]         rf_rv1,
  input  logic [DATA_W-1:0]         rf_rv2,
  output logic [DATA_W-1:0]         rv1,
  output logic [DATA_W-1:0]         rv2
`ifdef RF_WB_ARB_STATS_EN
  ,
  output logic [15:0]               conflict_cnt
`endif
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(RF_ZERO_REG);

  logic              transfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  logic              rf_we_q,     rf_we_d;
  logic [ADDR_W-1:0] rf_rd_q,     rf_rd_d;
  logic [DATA_W-1:0] rf_indata_q, rf_indata_d;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (transfer),
    .grant   (req_ready)
  );

  assign transfer = |req_ready;

  // Grant is one-hot, so OR-ing the masked slices selects the winner.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_rd   = sel_rd   | req_rd[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rf_we_d     = transfer && (sel_rd != ZERO_IDX);
    rf_rd_d     = rf_rd_q;
    rf_indata_d = rf_indata_q;
    if (transfer) begin
      rf_rd_d     = sel_rd;
      rf_indata_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_indata_q <= '0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_indata_q <= rf_indata_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_indata = rf_indata_q;

  // Forward the write landing this cycle; x0 always reads the raw file value.
  always_comb begin
    rv1 = rf_rv1;
    rv2 = rf_rv2;
    if (rf_we_q && (rf_rd_q == rs1) && (rs1 != ZERO_IDX)) begin
      rv1 = rf_indata_q;
    end
    if (rf_we_q && (rf_rd_q == rs2) && (rs2 != ZERO_IDX)) begin
      rv2 = rf_indata_q;
    end
  end

`ifdef RF_WB_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (multi_hot(8'(req_valid)) && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
